// File: rtl/pattern_serializer.sv
// pattern_serializer: bit-serial pattern transmitter for the sequence-detector labs.
//
// Captures Pattern[Length-1:0] on Start while idle and shifts it out MSB-first on w,
// one bit per clock. The pattern is sent Repeat+1 times back to back, then Done
// pulses for one cycle. Length above MAX_LEN is clamped, and Length=0 is ignored.
//
// Optional feature macro: SERIAL_PARITY_EN. When it is defined, every repetition is
// followed by one PARITY cycle that carries the even-parity bit of the sent field.
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   Start     in   transmit request, honoured only in IDLE
//   Pattern   in   [MAX_LEN] bits to send; active field Pattern[Length-1:0]
//   Length    in   [LEN_W] number of bits to send
//   Repeat    in   [4] extra repetitions (total sends = Repeat+1)
//   w         out  serial data; 0 whenever Valid=0
//   Valid     out  w carries a pattern or parity bit
//   Busy      out  not in IDLE
//   Done      out  one-cycle completion pulse
//   CurState  out  [2] state encoding (IDLE=0, SHIFT=1, PARITY=2, DONE=3)
module pattern_serializer #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [MAX_LEN-1:0] Pattern,
    input  logic [LEN_W-1:0]   Length,
    input  logic [3:0]         Repeat,
    output logic               w,
    output logic               Valid,
    output logic               Busy,
    output logic               Done,
    output logic [1:0]         CurState
);

    localparam int unsigned      REP_W     = 4;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] shreg_q, shreg_d;   // current bit always at the MSB
    logic [MAX_LEN-1:0] cap_q,   cap_d;     // left-aligned copy used to reload repeats
    logic [LEN_W-1:0]   cnt_q,   cnt_d;     // bits still to emit, including the current one
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [REP_W-1:0]   rep_q,   rep_d;

    logic               w_d, valid_d, busy_d, done_d;

    logic [LEN_W-1:0]   len_eff;
    logic [MAX_LEN-1:0] aligned;

    // Clamp the length and left-align the active field so the MSB is always sent first.
    always_comb begin
        len_eff = (Length > MAX_LEN_L) ? MAX_LEN_L : Length;
        aligned = Pattern << (MAX_LEN_L - len_eff);
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        rep_d   = rep_q;

        case (state_q)
            ST_IDLE: begin
                if (Start && (Length != '0)) begin
                    cap_d   = aligned;
                    shreg_d = aligned;
                    cnt_d   = len_eff;
                    len_d   = len_eff;
                    rep_d   = Repeat;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
`ifdef SERIAL_PARITY_EN
                    state_d = ST_PARITY;
`else
                    if (rep_q != '0) begin
                        // Reload in the same edge so repetitions run gap-free.
                        rep_d   = rep_q - REP_W'(1);
                        cnt_d   = len_q;
                        shreg_d = cap_q;
                    end else begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_PARITY: begin
                if (rep_q != '0) begin
                    rep_d   = rep_q - REP_W'(1);
                    cnt_d   = len_q;
                    shreg_d = cap_q;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are computed from the next state and registered alongside it.
        // Bits below the active field are zero after alignment, so XOR of the whole
        // captured copy is the parity of the sent bits.
        w_d     = 1'b0;
        valid_d = 1'b0;
        if (state_d == ST_SHIFT) begin
            w_d     = shreg_d[MAX_LEN-1];
            valid_d = 1'b1;
        end else if (state_d == ST_PARITY) begin
            w_d     = ^cap_d;
            valid_d = 1'b1;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            w       <= 1'b0;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            w       <= w_d;
            Valid   <= valid_d;
            Busy    <= busy_d;
            Done    <= done_d;
        end
    end

    assign CurState = state_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: self-checking bench for pattern_serializer.
// Vector table of {pattern, length, repeat, expected field length, expected sends};
// a bit-level reference stream is queued per vector and popped on every Valid cycle.
module tb_pattern_serializer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [7:0] Pattern;
    logic [3:0] Length;
    logic [3:0] Repeat;
    logic       w;
    logic       Valid;
    logic       Busy;
    logic       Done;
    logic [1:0] CurState;

    int n_chk  = 0;
    int n_pass = 0;

    logic       exp_q[$];
    logic [1:0] st_q[$];

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        logic [3:0] rep;
        int         exp_len;
        int         exp_sends;
    } vec_t;

    vec_t vt[8];

    pattern_serializer #(.MAX_LEN(8), .LEN_W(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Pattern  (Pattern),
        .Length   (Length),
        .Repeat   (Repeat),
        .w        (w),
        .Valid    (Valid),
        .Busy     (Busy),
        .Done     (Done),
        .CurState (CurState)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Called right after a negedge. Drives Start for one edge and follows the
    // transmission until Busy drops, comparing every cycle against the reference.
    task automatic run_vec(input string nm, input logic [7:0] pat, input logic [3:0] len,
                           input logic [3:0] rep, input int exp_len, input int exp_sends,
                           input int glitch_cyc);
        int   exp_done;
        int   ndone;
        int   done_cyc;
        int   cyc;
        logic eb;
        logic [1:0] es;
`ifdef SERIAL_PARITY_EN
        logic par;
`endif
        exp_q.delete();
        st_q.delete();
`ifdef SERIAL_PARITY_EN
        par = 1'b0;
        for (int i = 0; i < exp_len; i++) par ^= pat[i];
`endif
        for (int s = 0; s < exp_sends; s++) begin
            for (int i = exp_len - 1; i >= 0; i--) begin
                exp_q.push_back(pat[i]);
                st_q.push_back(2'd1);
            end
`ifdef SERIAL_PARITY_EN
            exp_q.push_back(par);
            st_q.push_back(2'd2);
`endif
        end
        exp_done = exp_q.size() + 1;
        ndone    = 0;
        done_cyc = 0;

        Pattern = pat;
        Length  = len;
        Repeat  = rep;
        Start   = 1'b1;
        for (cyc = 1; cyc <= 400; cyc++) begin
            @(negedge Clock);
            if (cyc == 1) Start = 1'b0;
            if (Valid) begin
                check({nm, "_busy"}, 32'(Busy), 32'd1);
                if (exp_q.size() == 0) begin
                    check({nm, "_extra_bit"}, 32'(exp_q.size()), 32'd1);
                end else begin
                    eb = exp_q.pop_front();
                    es = st_q.pop_front();
                    check({nm, "_w"}, 32'(w), 32'(eb));
                    check({nm, "_state"}, 32'(CurState), 32'(es));
                end
            end else begin
                check({nm, "_w_idle"}, 32'(w), 32'd0);
            end
            if (Done) begin
                ndone++;
                done_cyc = cyc;
                check({nm, "_done_state"}, 32'(CurState), 32'd3);
            end
            if (cyc == glitch_cyc) begin
                Start   = 1'b1;
                Pattern = 8'hFF;
                Length  = 4'd8;
                Repeat  = 4'hF;
            end else if (cyc == glitch_cyc + 1) begin
                Start = 1'b0;
            end
            if (!Busy) break;
        end
        check({nm, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check({nm, "_done_count"}, 32'(ndone), 32'd1);
        check({nm, "_bits_left"}, 32'(exp_q.size()), 32'd0);
        check({nm, "_busy_end"}, 32'(cyc), 32'(exp_done + 1));
        Start = 1'b0;
    endtask

    initial begin
        int first_done;
        int c;

        vt[0] = '{8'h0D, 4'd4,  4'd0,  4, 1};
        vt[1] = '{8'h0F, 4'd4,  4'd2,  4, 3};
        vt[2] = '{8'hA5, 4'd8,  4'd0,  8, 1};
        vt[3] = '{8'h5A, 4'd12, 4'd0,  8, 1};
        vt[4] = '{8'h03, 4'd1,  4'd3,  1, 4};
        vt[5] = '{8'h02, 4'd1,  4'd0,  1, 1};
        vt[6] = '{8'h96, 4'd5,  4'd1,  5, 2};
        vt[7] = '{8'hC3, 4'd8,  4'hF,  8, 16};

        Reset   = 1'b1;
        Start   = 1'b0;
        Pattern = 8'h00;
        Length  = 4'd0;
        Repeat  = 4'd0;

        // Outputs under reset.
        @(negedge Clock);
        check("rst_w",     32'(w),        32'd0);
        check("rst_valid", 32'(Valid),    32'd0);
        check("rst_busy",  32'(Busy),     32'd0);
        check("rst_done",  32'(Done),     32'd0);
        check("rst_state", 32'(CurState), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        // Vector table.
        for (int v = 0; v < 8; v++) begin
            run_vec($sformatf("vec%0d", v), vt[v].pat, vt[v].len, vt[v].rep,
                    vt[v].exp_len, vt[v].exp_sends, 0);
            @(negedge Clock);
        end

        // Length=0 with Start held: nothing happens.
        Pattern = 8'hFF;
        Length  = 4'd0;
        Repeat  = 4'd0;
        Start   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("len0_idle", 32'({Busy, Valid, Done}), 32'd0);
        end
        Start = 1'b0;
        @(negedge Clock);

        // Start re-pulsed with a new pattern mid-transmission: stream unchanged.
        run_vec("restart_ignored", 8'h0D, 4'd4, 4'd0, 4, 1, 2);
        @(negedge Clock);
        check("restart_idle", 32'(Busy), 32'd0);

        // Asynchronous reset mid-cycle 2.
        Pattern = 8'h0D;
        Length  = 4'd4;
        Repeat  = 4'd3;
        Start   = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("arst_pre_w", 32'(w), 32'd1);
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        check("arst_w",     32'(w),        32'd0);
        check("arst_valid", 32'(Valid),    32'd0);
        check("arst_busy",  32'(Busy),     32'd0);
        check("arst_done",  32'(Done),     32'd0);
        check("arst_state", 32'(CurState), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("arst_stay_idle", 32'(Busy), 32'd0);
        run_vec("after_reset", 8'h0D, 4'd4, 4'd0, 4, 1, 0);
        @(negedge Clock);

        // Start held high: one idle cycle between back-to-back transmissions.
`ifdef SERIAL_PARITY_EN
        first_done = 6;
`else
        first_done = 5;
`endif
        Pattern = 8'h0D;
        Length  = 4'd4;
        Repeat  = 4'd0;
        Start   = 1'b1;
        for (int i = 1; i <= first_done + 2; i++) begin
            @(negedge Clock);
            check("held_busy", 32'(Busy), (i == first_done + 1) ? 32'd0 : 32'd1);
            if (i == first_done) check("held_done", 32'(Done), 32'd1);
            if (i == first_done + 2) check("held_restart_w", 32'(w), 32'd1);
        end
        Start = 1'b0;
        c = 0;
        while (Busy && c < 40) begin
            @(negedge Clock);
            c++;
        end
        check("held_drain", 32'(Busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
